// File: rtl/fsquare_seq.sv
// fsquare_seq: sequential IEEE-754 square, out = x*x. The sign is always 0,
//   specials are bypassed, subnormal inputs and results flush to +0.
// Latency: normal operands give out_valid M+3 cycles after acceptance
//   (26 cycles single, 55 double). Specials give out_valid one cycle after acceptance.
// Backpressure: one operand in flight. in_ready is high only in IDLE. The result
//   holds in DONE until out_ready. out keeps the last result afterwards.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in1 operand handshake;
//   out_valid/out_ready/out result handshake.
// Build option: define FSQUARE_RNE_EN for round-to-nearest-even. Otherwise the
//   result is truncated. Latency is the same in both builds.

module fsquare_seq #(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out
);

  localparam int M    = (BUS_WIDTH == 64) ? 52 : 23;
  localparam int E    = (BUS_WIDTH == 64) ? 11 : 8;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int SW   = M + 1;          // significand width incl. hidden 1
  localparam int PW   = 2 * SW;         // product width
  localparam int CW   = $clog2(SW);     // multiplier bit counter width
  localparam int XW   = E + 2;          // signed exponent working width

  localparam logic [CW-1:0]        CNT_LAST = CW'(M);
  localparam logic [E-1:0]         EXP_ONES = '1;
  localparam logic [BUS_WIDTH-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
  localparam logic [BUS_WIDTH-1:0] PINF     = {1'b0, EXP_ONES, {M{1'b0}}};
  localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << E) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t               state_q, state_d;
  logic [E-1:0]         exp_q, exp_d;
  logic [PW-1:0]        mcand_q, mcand_d;   // multiplicand, shifts left each MUL cycle
  logic [SW-1:0]        mplier_q, mplier_d; // multiplier, LSB selects the add
  logic [PW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] out_q, out_d;

  logic [E-1:0]         in_exp;
  logic [M-1:0]         in_man;
  logic                 sign_unused;

  assign in_exp      = in1[BUS_WIDTH-2 -: E];
  assign in_man      = in1[M-1:0];
  // Squares are never negative, so the input sign plays no part.
  assign sign_unused = in1[BUS_WIDTH-1];

  // ---------------------------------------------------------------------
  // Normalise / round / range check of the finished product
  // ---------------------------------------------------------------------
  logic                    norm;
  logic [M-1:0]            man_t;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [M:0]              man_r;
  logic signed [XW-1:0]    exp_raw;
  logic signed [XW-1:0]    exp_f;
  logic [BUS_WIDTH-1:0]    norm_res;
`ifndef FSQUARE_RNE_EN
  logic                    trunc_unused;
`endif

  always_comb begin
    // The product of two values in [1,2) is in [1,4). The top bit decides whether
    // the binary point moves one place.
    norm = acc_q[PW-1];
    if (norm) begin
      man_t  = acc_q[PW-2 -: M];
      guard  = acc_q[M];
      sticky = |acc_q[M-1:0];
    end else begin
      man_t  = acc_q[PW-3 -: M];
      guard  = acc_q[M-1];
      sticky = |acc_q[M-2:0];
    end

`ifdef FSQUARE_RNE_EN
    // Round up above half, or at exactly half when that makes the LSB even.
    round_up = guard & (sticky | man_t[0]);
`else
    round_up     = 1'b0;
    trunc_unused = guard ^ sticky;
`endif

    exp_raw = $signed({1'b0, exp_q, 1'b0}) - BIAS_X
            + $signed({{(XW-1){1'b0}}, norm});
    man_r   = {1'b0, man_t} + {{M{1'b0}}, round_up};
    // A carry out of the mantissa leaves man_r[M-1:0] = 0, so only the exponent moves.
    exp_f   = exp_raw + $signed({{(XW-1){1'b0}}, man_r[M]});

    if (exp_f >= EXP_MAX) begin
      norm_res = PINF;
    end else if (exp_f <= EXP_ZERO) begin
      norm_res = '0;
    end else begin
      norm_res = {1'b0, exp_f[E-1:0], man_r[M-1:0]};
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM and datapath next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_exp == EXP_ONES) begin
            out_d   = (in_man != '0) ? QNAN : PINF;
            state_d = DONE;
          end else if (in_exp == '0) begin
            // Zero and subnormal operands flush to +0.
            out_d   = '0;
            state_d = DONE;
          end else begin
            exp_d    = in_exp;
            mcand_d  = {{SW{1'b0}}, 1'b1, in_man};
            mplier_d = {1'b1, in_man};
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end
        end
      end

      MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      NORM: begin
        out_d   = norm_res;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_fsquare_seq.sv
// tb_fsquare_seq: directed checks of fsquare_seq at BUS_WIDTH=32.
// Latency is counted in falling edges after the accepting rising edge.
//   Specials must show out_valid at count 1. Normal operands must show it at count 26.

module tb_fsquare_seq;

  localparam int W       = 32;
  localparam int LAT_NRM = 26;
  localparam int LAT_SPC = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fsquare_seq #(.BUS_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  // Presents one operand, then waits for out_valid. lat=0 means it never came.
  task automatic run_op(input logic [31:0] x, output int lat, output logic [31:0] res);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    in1      = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    res = out;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_vec++;
    if (out !== 32'h0) begin
      n_bad++; $display("FAIL reset_out: got %h want 00000000", out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_normal();
    logic [31:0] xs [6] = '{32'h40400000, 32'hC0000000, 32'h3F800000,
                            32'h3FC00000, 32'h3FFFFFFF, 32'hBFC00000};
    logic [31:0] ys [6] = '{32'h41100000, 32'h40800000, 32'h3F800000,
                            32'h40100000, 32'h407FFFFE, 32'h40100000};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], lat, res);
      n_vec++;
      if (res !== ys[i]) begin
        n_bad++; $display("FAIL normal_value x=%h: got %h want %h", xs[i], res, ys[i]);
      end
      n_vec++;
      if (lat != LAT_NRM) begin
        n_bad++; $display("FAIL normal_latency x=%h: got %0d want %0d", xs[i], lat, LAT_NRM);
      end
      consume();
    end
  endtask

  task automatic test_special();
    logic [31:0] xs [6] = '{32'h7fc00001, 32'hff800000, 32'h80000000,
                            32'h00000001, 32'h7f800000, 32'hffc00000};
    logic [31:0] ys [6] = '{32'h7fc00000, 32'h7f800000, 32'h00000000,
                            32'h00000000, 32'h7f800000, 32'h7fc00000};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], lat, res);
      n_vec++;
      if (res !== ys[i]) begin
        n_bad++; $display("FAIL special_value x=%h: got %h want %h", xs[i], res, ys[i]);
      end
      n_vec++;
      if (lat != LAT_SPC) begin
        n_bad++; $display("FAIL special_latency x=%h: got %0d want %0d", xs[i], lat, LAT_SPC);
      end
      consume();
    end
  endtask

  task automatic test_range();
    logic [31:0] xs [7] = '{32'h60AD78EC, 32'h1E1AB8CB, 32'h5F000000, 32'h5F800000,
                            32'h20000000, 32'h1F800000, 32'h1FC00000};
    logic [31:0] ys [7] = '{32'h7f800000, 32'h00000000, 32'h7E800000, 32'h7f800000,
                            32'h00800000, 32'h00000000, 32'h00000000};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 7; i++) begin
      run_op(xs[i], lat, res);
      n_vec++;
      if (res !== ys[i] || lat != LAT_NRM) begin
        n_bad++;
        $display("FAIL range x=%h: got %h lat %0d want %h lat %0d", xs[i], res, lat, ys[i], LAT_NRM);
      end
      consume();
    end
  endtask

  task automatic test_rounding();
    int lat;
    logic [31:0] res;
    logic [31:0] want;
`ifdef FSQUARE_RNE_EN
    want = 32'h3F801003;
`else
    want = 32'h3F801002;
`endif
    run_op(32'h3F800801, lat, res);
    n_vec++;
    if (res !== want || lat != LAT_NRM) begin
      n_bad++; $display("FAIL rounding: got %h lat %0d want %h lat %0d", res, lat, want, LAT_NRM);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    logic [31:0] res;
    run_op(32'h40400000, lat, res);
    n_vec++;
    if (res !== 32'h41100000) begin
      n_bad++; $display("FAIL bp_first: got %h want 41100000", res);
    end
    for (int k = 0; k < 10; k++) begin
      in1      = 32'h40000000;
      in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out !== 32'h41100000 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got valid=%b out=%h ready=%b want 1/41100000/0",
                 k, out_valid, out, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'h41100000) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b ready=%b out=%h want 0/1/41100000",
               out_valid, in_ready, out);
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_bad++; $display("FAIL bp_ignored_input: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int seen;
    logic [31:0] res;
    @(negedge clk);
    in1      = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_busy: got in_ready=%b want 0", in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_async_reset: got valid=%b ready=%b out=%h want 0/1/00000000",
               out_valid, in_ready, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_bad++; $display("FAIL mid_discard: got %0d valid cycles want 0", seen);
    end
    run_op(32'h40400000, lat, res);
    n_vec++;
    if (res !== 32'h41100000 || lat != LAT_NRM) begin
      n_bad++; $display("FAIL mid_recover: got %h lat %0d want 41100000 lat %0d", res, lat, LAT_NRM);
    end
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_rounding();
    test_backpressure();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
